// File: rtl/riscv_mem_pkg.sv
// Shared memory-side constants for the core's load/store path.
// word_idx() strips the byte offset from a byte address.
package riscv_mem_pkg;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int WORD_IDX_W = ADDR_W - 2;

  function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sb_match.sv
// Store-buffer forwarding lookup: compares the load word index against every entry
// and selects the youngest valid match, walking backwards from the write pointer.
module sb_match
  import riscv_mem_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  IDX_W = WORD_IDX_W,
  parameter int  DW    = DATA_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_valid,
  input  logic [IDX_W-1:0] i_idx   [DEPTH],
  input  logic [DW-1:0]    i_data  [DEPTH],
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  logic [IDX_W-1:0] i_ld_idx,
  output logic             o_hit,
  output logic [DW-1:0]    o_data
);

  logic [PTR_W-1:0] w_slot;
  logic             w_match;

  // Oldest-to-youngest scan: a later (younger) match overwrites an earlier one.
  always_comb begin
    o_hit   = 1'b0;
    o_data  = '0;
    w_slot  = '0;
    w_match = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_slot  = i_wr_ptr - PTR_W'(k);
      w_match = i_valid[w_slot] && (i_idx[w_slot] == i_ld_idx);
      o_hit   = o_hit | w_match;
      o_data  = w_match ? i_data[w_slot] : o_data;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores drained to data memory on load-free cycles,
// with youngest-first forwarding to loads. Loads always own the memory port.
module store_buffer #(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = riscv_mem_pkg::ADDR_W,
  parameter int  DATA_W = riscv_mem_pkg::DATA_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_hit,
  input  logic              fence_req,
  output logic              fence_done,
  output logic [CNT_W-1:0]  count,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = ADDR_W - 2;

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [IDX_W-1:0]  w_idx [DEPTH];
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd;
  logic              w_unused;

  // fence_req only documents core intent; draining follows from the core withholding loads.
  assign w_unused   = fence_req;
  assign st_ready   = (r_count < CNT_W'(DEPTH));
  assign fence_done = (r_count == '0);
  assign count      = r_count;
  assign w_push     = st_valid && st_ready;
  assign w_pop      = !ld_req && (r_count != '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_idx
    assign w_idx[g] = r_addr[g][ADDR_W-1:2];
  end

  sb_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .DW    (DATA_W)
  ) u_match (
    .i_valid  (r_valid),
    .i_idx    (w_idx),
    .i_data   (r_data),
    .i_wr_ptr (r_wr_ptr),
    .i_ld_idx (ld_addr[ADDR_W-1:2]),
    .o_hit    (w_hit),
    .o_data   (w_fwd)
  );

  // Pointers, occupancy and entry valid bits; full/empty come from occupancy only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload; qualified by r_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr;
      r_data[r_wr_ptr] <= st_data;
    end
  end

  // Memory port arbitration: a load takes the port, otherwise the head entry drains.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_data   = '0;
    ld_hit    = 1'b0;
    if (ld_req) begin
      mem_read = 1'b1;
      mem_addr = ld_addr;
      ld_hit   = w_hit;
      ld_data  = w_hit ? w_fwd : mem_rdata;
    end else if (r_count != '0) begin
      mem_write = 1'b1;
      mem_addr  = r_addr[r_rd_ptr];
      mem_wdata = r_data[r_rd_ptr];
    end else begin
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer against a queue-based reference model
// and a behavioural word memory.
module tb_store_buffer;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic        ld_req;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        fence_req;
  logic        fence_done;
  logic [2:0]  count;
  logic        mem_read;
  logic        mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [8:0]  a;
    logic [31:0] d;
  } st_t;

  logic [31:0] tb_mem  [128] = '{default: 32'h0};
  logic [31:0] ref_mem [128] = '{default: 32'h0};
  st_t         q[$];
  int          checks = 0;
  int          errors = 0;

  store_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_hit     (ld_hit),
    .fence_req  (fence_req),
    .fence_done (fence_done),
    .count      (count),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with combinational read
  assign mem_rdata = tb_mem[word_idx(mem_addr)];
  always @(posedge clk) begin
    if (mem_write) tb_mem[word_idx(mem_addr)] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs against the model, advance model.
  task automatic cycle(input bit sv, input logic [8:0] sa, input logic [31:0] sd,
                       input bit lr, input logic [8:0] la);
    bit          hit;
    logic [31:0] fwd;
    bit          push_ok;
    bit          pop;
    st_valid = sv; st_addr = sa; st_data = sd; ld_req = lr; ld_addr = la;
    #4;
    hit = 1'b0;
    fwd = 32'h0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && word_idx(q[i].a) == word_idx(la)) begin
        hit = 1'b1;
        fwd = q[i].d;
      end
    end
    check_eq("count", 32'(count), 32'(q.size()));
    check_eq("st_ready", 32'(st_ready), 32'(q.size() < 4));
    check_eq("fence_done", 32'(fence_done), 32'(q.size() == 0));
    if (lr) begin
      check_eq("ld_mem_read", 32'(mem_read), 32'd1);
      check_eq("ld_mem_write", 32'(mem_write), 32'd0);
      check_eq("ld_mem_addr", 32'(mem_addr), 32'(la));
      check_eq("ld_hit", 32'(ld_hit), 32'(hit));
      check_eq("ld_data", ld_data, hit ? fwd : ref_mem[word_idx(la)]);
    end else begin
      check_eq("idle_mem_read", 32'(mem_read), 32'd0);
      check_eq("idle_ld_hit", 32'(ld_hit), 32'd0);
      check_eq("idle_ld_data", ld_data, 32'd0);
      if (q.size() > 0) begin
        check_eq("drain_write", 32'(mem_write), 32'd1);
        check_eq("drain_addr", 32'(mem_addr), 32'(q[0].a));
        check_eq("drain_wdata", mem_wdata, q[0].d);
      end else begin
        check_eq("empty_write", 32'(mem_write), 32'd0);
        check_eq("empty_addr", 32'(mem_addr), 32'd0);
        check_eq("empty_wdata", mem_wdata, 32'd0);
      end
    end
    push_ok = sv && (q.size() < 4);
    pop     = !lr && (q.size() > 0);
    if (pop) begin
      ref_mem[word_idx(q[0].a)] = q[0].d;
      q.delete(0);
    end
    if (push_ok) q.push_back('{a: sa, d: sd});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_count"}, 32'(count), 32'd0);
    check_eq({tag, "_st_ready"}, 32'(st_ready), 32'd1);
    check_eq({tag, "_fence_done"}, 32'(fence_done), 32'd1);
    check_eq({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check_eq({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check_eq({tag, "_ld_hit"}, 32'(ld_hit), 32'd0);
    check_eq({tag, "_ld_data"}, ld_data, 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = 9'h0; st_data = 32'h0;
    ld_req = 1'b0; ld_addr = 9'h0; fence_req = 1'b0;
    #3;
    check_reset_state("por");
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single store drains one cycle after push
    cycle(1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 9'h0);
    cycle(1'b0, 9'h0, 32'h0, 1'b0, 9'h0);
    cycle(1'b0, 9'h0, 32'h0, 1'b0, 9'h0);
    check_eq("mem_0x010", tb_mem[4], 32'hDEADBEEF);

    // Two stores to one word under loads; youngest forwards with byte offset ignored
    cycle(1'b1, 9'h020, 32'h1, 1'b1, 9'h100);
    cycle(1'b1, 9'h020, 32'h2, 1'b1, 9'h100);
    cycle(1'b0, 9'h0, 32'h0, 1'b1, 9'h022);
    check_eq("fwd_youngest", ld_data, 32'h2);

    // Fill to DEPTH with loads held, 5th store stalls, then drain in order
    cycle(1'b1, 9'h030, 32'h30, 1'b1, 9'h020);
    cycle(1'b1, 9'h034, 32'h34, 1'b1, 9'h034);
    cycle(1'b1, 9'h038, 32'h38, 1'b1, 9'h038);
    for (int i = 0; i < 4; i++) cycle(1'b0, 9'h0, 32'h0, 1'b0, 9'h0);
    check_eq("stalled_not_written", tb_mem[14], 32'h0);

    // Same-cycle push is invisible to the load, visible one cycle later
    cycle(1'b1, 9'h040, 32'h55, 1'b1, 9'h040);
    cycle(1'b0, 9'h0, 32'h0, 1'b1, 9'h041);
    cycle(1'b0, 9'h0, 32'h0, 1'b0, 9'h0);

    // Reset with three stores buffered discards them
    cycle(1'b1, 9'h050, 32'hA1, 1'b1, 9'h100);
    cycle(1'b1, 9'h054, 32'hA2, 1'b1, 9'h100);
    cycle(1'b1, 9'h058, 32'hA3, 1'b1, 9'h100);
    ld_req = 1'b0; st_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 9'h0, 32'h0, 1'b0, 9'h0);
    check_eq("rst_discard", tb_mem[20], 32'h0);

    // Interleaved push/drain across pointer wrap
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 9'(9'h080 + 4 * i), $urandom, (i % 3) == 2, 9'h080);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 2) != 0, 9'($urandom_range(0, 63)), $urandom,
            $urandom_range(0, 9) < 4, 9'($urandom_range(0, 63)));

    n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle(1'b0, 9'h0, 32'h0, 1'b0, 9'h0);
      n++;
    end
    check_eq("drain_bound", 32'(q.size()), 32'd0);
    check_eq("final_count", 32'(count), 32'd0);
    for (int w = 0; w < 128; w++) check_eq("mem_image", tb_mem[w], ref_mem[w]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
